// File: rtl/adder_mon_pkg.sv
// Shared types and constants for the approximate-adder error monitor.
// Holds the default datapath width and the monitor FSM state encoding.
package adder_mon_pkg;

    localparam int WIDTH = 16;
    localparam int ED_W  = WIDTH + 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/error_distance.sv
// Combinational error distance between the exact and approximate sums.
// Ports: a, b, cin (adder operands); approx_sum, approx_cout (adder output); ed.
module error_distance
    import adder_mon_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    input  logic [W-1:0] approx_sum,
    input  logic         approx_cout,
    output logic [W:0]   ed
);

    logic [W:0] exact;
    logic [W:0] approx;

    assign exact  = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
    assign approx = {approx_cout, approx_sum};

    // Compare first so the unsigned subtraction never wraps.
    assign ed = (exact >= approx) ? (exact - approx) : (approx - exact);

endmodule

// File: rtl/adder_error_monitor.sv
// Accumulates error statistics of an approximate adder over a run of samples.
// Ports: start/in_valid/in_ready handshake, operands and approximate result in;
// busy/done status, sample/error counts, max/sum/last ED out.
module adder_error_monitor #(
    parameter int WIDTH       = 16,
    parameter int CNT_W       = 16,
    parameter int NUM_SAMPLES = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       op_a,
    input  logic [WIDTH-1:0]       op_b,
    input  logic                   op_cin,
    input  logic [WIDTH-1:0]       approx_sum,
    input  logic                   approx_cout,
    output logic                   busy,
    output logic                   done,
    output logic [CNT_W-1:0]       sample_count,
    output logic [CNT_W-1:0]       err_count,
    output logic [WIDTH:0]         max_ed,
    output logic [WIDTH+CNT_W:0]   sum_ed,
    output logic [WIDTH:0]         last_ed,
    output logic                   last_ed_valid
);

    import adder_mon_pkg::*;

    localparam int SW = WIDTH + 1 + CNT_W;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_SAMPLES - 1);
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    state_t state_q;
    state_t state_d;

    logic accept;
    logic start_ok;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [WIDTH-1:0] s1_sum;
    logic             s1_cout;
    logic [WIDTH:0]   ed_c;
    logic             s2_valid;

    assign in_ready      = (state_q == RUN);
    assign busy          = (state_q == RUN) || (state_q == DRAIN);
    assign done          = (state_q == DONE);
    assign accept        = in_valid & in_ready;
    assign start_ok      = start & ((state_q == IDLE) || (state_q == DONE));
    assign last_ed_valid = s2_valid;

    error_distance #(.W(WIDTH)) u_ed (
        .a           (s1_a),
        .b           (s1_b),
        .cin         (s1_cin),
        .approx_sum  (s1_sum),
        .approx_cout (s1_cout),
        .ed          (ed_c)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = RUN;
            end
            RUN: begin
                if (accept && sample_count == LAST) state_d = DRAIN;
            end
            DRAIN: begin
                // Stage 2 retires on this edge, so the pipeline is empty after it.
                if (!s1_valid) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            s1_valid     <= 1'b0;
            s1_a         <= '0;
            s1_b         <= '0;
            s1_cin       <= 1'b0;
            s1_sum       <= '0;
            s1_cout      <= 1'b0;
            s2_valid     <= 1'b0;
            last_ed      <= '0;
            sample_count <= '0;
            err_count    <= '0;
            max_ed       <= '0;
            sum_ed       <= '0;
        end else begin
            state_q  <= state_d;
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (accept) begin
                s1_a    <= op_a;
                s1_b    <= op_b;
                s1_cin  <= op_cin;
                s1_sum  <= approx_sum;
                s1_cout <= approx_cout;
            end
            if (start_ok) begin
                sample_count <= '0;
                err_count    <= '0;
                max_ed       <= '0;
                sum_ed       <= '0;
                last_ed      <= '0;
            end else begin
                if (s1_valid) last_ed <= ed_c;
                if (accept) sample_count <= sample_count + ONE;
                if (s2_valid) begin
                    if (last_ed != '0) err_count <= err_count + ONE;
                    if (last_ed > max_ed) max_ed <= last_ed;
                    sum_ed <= sum_ed + SW'(last_ed);
                end
            end
        end
    end

endmodule

// File: doc/adder_error_monitor.md
Name: adder_error_monitor

Overview:
- Downstream stage of the 16-bit segmented approximate adder.
- Each cycle it takes the adder's operands and its approximate result {Co_I, S_I}, computes the exact sum, and derives the error distance (ED).
- Over a run of NUM_SAMPLES it accumulates error statistics: error count, maximum ED and summed ED. These feed the team's accuracy characterisation (error rate, MED).

Parameters:
- WIDTH, 16, operand and sum width; ED width is WIDTH+1
- CNT_W, 16, width of the sample and error counters
- NUM_SAMPLES, 256, samples per run; legal range 1 to 2^CNT_W-1

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a run from IDLE or DONE
- in_valid  in  1  sample present on op_*/approx_*
- in_ready  out  1  block accepts a sample this cycle
- op_a  in  WIDTH  operand A fed to the adder
- op_b  in  WIDTH  operand B fed to the adder
- op_cin  in  1  carry-in fed to the adder
- approx_sum  in  WIDTH  adder sum output
- approx_cout  in  1  adder carry-out
- busy  out  1  high in RUN and DRAIN
- done  out  1  high in DONE
- sample_count  out  CNT_W  samples accepted in the current run
- err_count  out  CNT_W  samples with ED != 0
- max_ed  out  WIDTH+1  largest ED seen
- sum_ed  out  WIDTH+1+CNT_W  sum of all EDs; cannot overflow in legal range
- last_ed  out  WIDTH+1  ED of the most recent sample
- last_ed_valid  out  1  one-cycle pulse, last_ed updated

Behaviour:
- Reset (async, any state): state goes to IDLE. All outputs and all internal pipeline valids go to 0. Any in-flight samples are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE --start--> RUN. DONE --start--> RUN. start is ignored in RUN and DRAIN.
- On entry to RUN: sample_count, err_count, max_ed, sum_ed and last_ed all clear to 0 on the same edge that samples start.
- in_ready = (state==RUN). Accept = in_valid & in_ready. in_valid outside RUN is ignored.
- RUN -> DRAIN on the edge accepting sample number NUM_SAMPLES. in_ready is 0 from the next cycle.
- DRAIN -> DONE when both pipeline valids are 0, i.e. 2 cycles after the last accept.
- DONE holds all statistics stable until the next start or reset.
- Arithmetic:
  - exact = op_a + op_b + op_cin, zero-extended to WIDTH+1.
  - approx = {approx_cout, approx_sum}.
  - ED = |exact - approx|, unsigned, computed without wrap by comparing first.
- Pipeline timing, for a sample accepted at edge k:
  - Edge k: sample_count increments; inputs are registered into stage 1.
  - Edge k+1: the ED register loads. last_ed and last_ed_valid are visible after k+1.
  - Edge k+2: err_count += (ED!=0); max_ed = max(max_ed, ED); sum_ed += ED.
- Full throughput: one sample per cycle, back-to-back, no bubbles required.
- Latency from accept to statistics visible: 2 cycles.

Decomposition:
- Shared package adder_mon_pkg:
  - WIDTH and ED_W constants
  - state enum {IDLE, RUN, DRAIN, DONE}
- Sub-module error_distance: combinational.
  - Inputs: a, b, cin, approx_sum, approx_cout.
  - Output: ED.
  - Reused later for other approximate-adder monitors.
- Top level holds the FSM, the pipeline registers and the accumulators.

Test Plan:
- Correct result: NUM_SAMPLES=1; a=0x00FF, b=0x0001, cin=0, approx {0,0x0100} -> last_ed=0, err_count=0, sum_ed=0, done high 2 cycles after accept.
- Low approximation: a=0x00FF, b=0x0001, cin=0, approx {0,0x0000} -> ED=0x100; err_count=1, max_ed=0x100, sum_ed=0x100.
- Carry-out wrap: a=0xFFFF, b=0x0001, cin=1, approx {1,0x0000} -> exact 0x10001, ED=1. Also a=0x0002, b=0x0003, cin=0, approx {0,0x0007} -> ED=2, covering approx > exact.
- Sample-count boundary: NUM_SAMPLES=4; in_valid held high for 6 cycles with EDs 0, 3, 5, 1 -> in_ready drops after the 4th accept, sample_count=4, err_count=3, max_ed=5, sum_ed=9. Extra samples are ignored. done asserts exactly 2 cycles after the 4th accept.
- Restart and ignored start: in DONE, pulse start -> all statistics are 0 on the next cycle and in_ready=1. start pulsed during RUN -> no effect on sample_count.
- Reset mid-run: assert rst after 2 of 4 accepts -> all outputs are 0 immediately, including last_ed_valid. After release the state is IDLE and in_ready=0 until start.
